// File: rtl/reorder_buffer.sv
// Sixteen-entry in-order reorder buffer: allocate at tail, complete by index, retire one entry per cycle from head.
// Latency: allocation or completion at edge N is visible to commit/bypass in cycle N+1; every output is decoded from registered state.
// Backpressure: out_full refuses allocation using the registered count, so a same-cycle commit does not free a slot until the next cycle.
// Ports: clk/reset (async, active-high); in_allocate_* -> out_allocate_idx/out_full/out_empty;
//        in_ex_* / in_mem_* completion ports (mem wins on a same-index collision);
//        in_rs1/in_rs2 -> out_rsN_bypass/_bypass_value/_pending; out_commit_* retire port; out_exception_* precise trap.
module reorder_buffer #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_allocate,
  input  logic [4:0]       in_allocate_rd,
  input  logic             in_allocate_write_enable,
  input  logic [31:0]      in_allocate_PC,
  output logic [IDX_W-1:0] out_allocate_idx,
  output logic             out_full,
  output logic             out_empty,
  input  logic             in_ex_complete,
  input  logic [IDX_W-1:0] in_ex_complete_idx,
  input  logic [31:0]      in_ex_complete_value,
  input  logic [2:0]       in_ex_exception_vector,
  input  logic             in_mem_complete,
  input  logic [IDX_W-1:0] in_mem_complete_idx,
  input  logic [31:0]      in_mem_complete_value,
  input  logic [2:0]       in_mem_exception_vector,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  output logic             out_rs1_bypass,
  output logic             out_rs2_bypass,
  output logic [31:0]      out_rs1_bypass_value,
  output logic [31:0]      out_rs2_bypass_value,
  output logic             out_rs1_pending,
  output logic             out_rs2_pending,
  output logic             out_commit_valid,
  output logic [4:0]       out_commit_rd,
  output logic [31:0]      out_commit_value,
  output logic             out_commit_write_enable,
  output logic             out_exception,
  output logic [2:0]       out_exception_vector,
  output logic [31:0]      out_exception_PC
);

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(ENTRIES);
  localparam logic [IDX_W:0] ONE_CNT  = (IDX_W+1)'(1);

  // Per-entry state
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] cmp_q, cmp_d;
  logic [ENTRIES-1:0] we_q, we_d;
  logic [4:0]         rd_q  [ENTRIES];
  logic [4:0]         rd_d  [ENTRIES];
  logic [31:0]        pc_q  [ENTRIES];
  logic [31:0]        pc_d  [ENTRIES];
  logic [31:0]        val_q [ENTRIES];
  logic [31:0]        val_d [ENTRIES];
  logic [2:0]         exc_q [ENTRIES];
  logic [2:0]         exc_d [ENTRIES];

  logic [IDX_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]     count_q, count_d;

  logic head_done, head_exc, alloc_acc, ex_fire, mem_fire;

  // Status and retire decode, purely from registered state
  assign out_allocate_idx = tail_q;
  assign out_full         = (count_q == FULL_CNT);
  assign out_empty        = (count_q == '0);

  assign head_done = valid_q[head_q] && cmp_q[head_q];
  assign head_exc  = (exc_q[head_q] != 3'b000);

  assign out_commit_valid        = head_done && !head_exc;
  assign out_commit_rd           = out_commit_valid ? rd_q[head_q]  : 5'd0;
  assign out_commit_value        = out_commit_valid ? val_q[head_q] : 32'd0;
  assign out_commit_write_enable = out_commit_valid && we_q[head_q] && (rd_q[head_q] != 5'd0);

  assign out_exception        = head_done && head_exc;
  assign out_exception_vector = out_exception ? exc_q[head_q] : 3'b000;
  assign out_exception_PC     = out_exception ? pc_q[head_q]  : 32'd0;

  assign alloc_acc = in_allocate && !out_full && !out_exception;
  assign ex_fire   = in_ex_complete  && valid_q[in_ex_complete_idx];
  assign mem_fire  = in_mem_complete && valid_q[in_mem_complete_idx];

  // Bypass search: walk from head toward tail so the last hit is the youngest producer.
  logic [4:0]       rs      [2];
  logic [1:0]       byp, pend;
  logic [31:0]      byp_val [2];
  logic             bp_hit;
  logic [IDX_W-1:0] bp_idx, scan_idx;

  assign rs[0] = in_rs1;
  assign rs[1] = in_rs2;

  always_comb begin
    byp      = '0;
    pend     = '0;
    byp_val  = '{default: '0};
    bp_hit   = 1'b0;
    bp_idx   = '0;
    scan_idx = '0;
    for (int s = 0; s < 2; s++) begin
      bp_hit = 1'b0;
      bp_idx = '0;
      for (int k = 0; k < ENTRIES; k++) begin
        scan_idx = head_q + IDX_W'(k);
        if (valid_q[scan_idx] && we_q[scan_idx] && (rd_q[scan_idx] == rs[s]) && (rs[s] != 5'd0)) begin
          bp_hit = 1'b1;
          bp_idx = scan_idx;
        end
      end
      byp[s]     = bp_hit && cmp_q[bp_idx] && (exc_q[bp_idx] == 3'b000);
      pend[s]    = bp_hit && !cmp_q[bp_idx];
      byp_val[s] = byp[s] ? val_q[bp_idx] : 32'd0;
    end
  end

  assign out_rs1_bypass       = byp[0];
  assign out_rs2_bypass       = byp[1];
  assign out_rs1_pending      = pend[0];
  assign out_rs2_pending      = pend[1];
  assign out_rs1_bypass_value = byp_val[0];
  assign out_rs2_bypass_value = byp_val[1];

  // Next state
  always_comb begin
    valid_d = valid_q;
    cmp_d   = cmp_q;
    we_d    = we_q;
    rd_d    = rd_q;
    pc_d    = pc_q;
    val_d   = val_q;
    exc_d   = exc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (out_exception) begin
      // Precise trap: everything younger than (and including) head is squashed,
      // and same-cycle completions/allocations are dropped.
      valid_d = '0;
      cmp_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (ex_fire) begin
        cmp_d[in_ex_complete_idx] = 1'b1;
        val_d[in_ex_complete_idx] = in_ex_complete_value;
        exc_d[in_ex_complete_idx] = in_ex_exception_vector;
      end
      // Applied second so it overrides the execute port on an index collision.
      if (mem_fire) begin
        cmp_d[in_mem_complete_idx] = 1'b1;
        val_d[in_mem_complete_idx] = in_mem_complete_value;
        exc_d[in_mem_complete_idx] = in_mem_exception_vector;
      end
      if (out_commit_valid) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + IDX_W'(1);
      end
      // Tail slot is never valid when allocation is accepted, so it cannot
      // collide with a completion or with the retiring head.
      if (alloc_acc) begin
        valid_d[tail_q] = 1'b1;
        cmp_d[tail_q]   = 1'b0;
        we_d[tail_q]    = in_allocate_write_enable;
        rd_d[tail_q]    = in_allocate_rd;
        pc_d[tail_q]    = in_allocate_PC;
        val_d[tail_q]   = 32'd0;
        exc_d[tail_q]   = 3'b000;
        tail_d          = tail_q + IDX_W'(1);
      end
      unique case ({alloc_acc, out_commit_valid})
        2'b10:   count_d = count_q + ONE_CNT;
        2'b01:   count_d = count_q - ONE_CNT;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      cmp_q   <= '0;
      we_q    <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        rd_q[i]  <= '0;
        pc_q[i]  <= '0;
        val_q[i] <= '0;
        exc_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      cmp_q   <= cmp_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      pc_q    <= pc_d;
      val_q   <= val_d;
      exc_q   <= exc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer: directed scenarios plus a randomized run against a queue-based model.
// Inputs are driven 1ns after the rising edge; outputs are sampled 1ns after that, well away from the edge.
// Ends with a single summary line of error and check counts.
module tb_reorder_buffer;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic clk, reset;
  logic in_allocate, in_allocate_write_enable;
  logic [4:0] in_allocate_rd;
  logic [31:0] in_allocate_PC;
  logic [IDX_W-1:0] out_allocate_idx;
  logic out_full, out_empty;
  logic in_ex_complete, in_mem_complete;
  logic [IDX_W-1:0] in_ex_complete_idx, in_mem_complete_idx;
  logic [31:0] in_ex_complete_value, in_mem_complete_value;
  logic [2:0] in_ex_exception_vector, in_mem_exception_vector;
  logic [4:0] in_rs1, in_rs2;
  logic out_rs1_bypass, out_rs2_bypass, out_rs1_pending, out_rs2_pending;
  logic [31:0] out_rs1_bypass_value, out_rs2_bypass_value;
  logic out_commit_valid, out_commit_write_enable, out_exception;
  logic [4:0] out_commit_rd;
  logic [31:0] out_commit_value, out_exception_PC;
  logic [2:0] out_exception_vector;

  int errors = 0;
  int checks = 0;

  reorder_buffer #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset),
    .in_allocate(in_allocate), .in_allocate_rd(in_allocate_rd),
    .in_allocate_write_enable(in_allocate_write_enable), .in_allocate_PC(in_allocate_PC),
    .out_allocate_idx(out_allocate_idx), .out_full(out_full), .out_empty(out_empty),
    .in_ex_complete(in_ex_complete), .in_ex_complete_idx(in_ex_complete_idx),
    .in_ex_complete_value(in_ex_complete_value), .in_ex_exception_vector(in_ex_exception_vector),
    .in_mem_complete(in_mem_complete), .in_mem_complete_idx(in_mem_complete_idx),
    .in_mem_complete_value(in_mem_complete_value), .in_mem_exception_vector(in_mem_exception_vector),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_rs1_bypass(out_rs1_bypass), .out_rs2_bypass(out_rs2_bypass),
    .out_rs1_bypass_value(out_rs1_bypass_value), .out_rs2_bypass_value(out_rs2_bypass_value),
    .out_rs1_pending(out_rs1_pending), .out_rs2_pending(out_rs2_pending),
    .out_commit_valid(out_commit_valid), .out_commit_rd(out_commit_rd),
    .out_commit_value(out_commit_value), .out_commit_write_enable(out_commit_write_enable),
    .out_exception(out_exception), .out_exception_vector(out_exception_vector),
    .out_exception_PC(out_exception_PC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    in_allocate = 0; in_allocate_rd = 0; in_allocate_write_enable = 0; in_allocate_PC = 0;
    in_ex_complete = 0; in_ex_complete_idx = 0; in_ex_complete_value = 0; in_ex_exception_vector = 0;
    in_mem_complete = 0; in_mem_complete_idx = 0; in_mem_complete_value = 0; in_mem_exception_vector = 0;
    in_rs1 = 0; in_rs2 = 0;
  endtask

  // Advance one cycle; inputs applied before the call are sampled at this edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic we, input logic [31:0] pc);
    in_allocate = 1; in_allocate_rd = rd; in_allocate_write_enable = we; in_allocate_PC = pc;
    tick();
    in_allocate = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    #3;
    checks++; if (out_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0d want 1", out_empty); end
    checks++; if (out_allocate_idx !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", out_allocate_idx); end
    checks++; if ({out_full, out_commit_valid, out_exception, out_rs1_bypass, out_rs1_pending} !== 5'b0)
      begin errors++; $display("FAIL reset_flags: got %b want 00000", {out_full, out_commit_valid, out_exception, out_rs1_bypass, out_rs1_pending}); end
    tick();
    reset = 0;
    #1;
  endtask

  task automatic test_inorder_commit();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_allocate_idx !== 4'(i)) begin errors++; $display("FAIL alloc_idx%0d: got %0d want %0d", i, out_allocate_idx, i); end
      alloc(5'(5 + i), 1'b1, 32'(i * 4));
    end
    in_ex_complete = 1; in_ex_complete_idx = 4'd1; in_ex_complete_value = 32'h22;
    tick(); idle();
    checks++; if (out_commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_hold: got %0d want 0", out_commit_valid); end
    in_ex_complete = 1; in_ex_complete_idx = 4'd0; in_ex_complete_value = 32'h11;
    tick(); idle();
    checks++; if ({out_commit_valid, out_commit_write_enable, out_commit_rd, out_commit_value} !== {1'b1, 1'b1, 5'd5, 32'h11})
      begin errors++; $display("FAIL commit0: got v=%0d we=%0d rd=%0d val=%h want 1 1 5 11", out_commit_valid, out_commit_write_enable, out_commit_rd, out_commit_value); end
    tick();
    checks++; if ({out_commit_valid, out_commit_rd, out_commit_value} !== {1'b1, 5'd6, 32'h22})
      begin errors++; $display("FAIL commit1: got v=%0d rd=%0d val=%h want 1 6 22", out_commit_valid, out_commit_rd, out_commit_value); end
    tick();
    checks++; if ({out_commit_valid, out_empty} !== 2'b00) begin errors++; $display("FAIL idx2_held: got v=%0d empty=%0d want 0 0", out_commit_valid, out_empty); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < ENTRIES; i++) alloc(5'(i + 1), 1'b1, 32'(i * 4));
    checks++; if ({out_full, out_allocate_idx} !== {1'b1, 4'd0}) begin errors++; $display("FAIL full_set: got full=%0d idx=%0d want 1 0", out_full, out_allocate_idx); end
    alloc(5'd20, 1'b1, 32'h999);
    checks++; if ({out_full, out_allocate_idx, out_commit_valid} !== {1'b1, 4'd0, 1'b0})
      begin errors++; $display("FAIL full_reject: got full=%0d idx=%0d cv=%0d want 1 0 0", out_full, out_allocate_idx, out_commit_valid); end
    in_ex_complete = 1; in_ex_complete_idx = 4'd0; in_ex_complete_value = 32'h55;
    tick(); idle();
    checks++; if ({out_full, out_commit_valid} !== 2'b11) begin errors++; $display("FAIL full_commit: got full=%0d cv=%0d want 1 1", out_full, out_commit_valid); end
    // Allocate alongside the commit: refused because full is registered.
    alloc(5'd9, 1'b1, 32'h40);
    checks++; if ({out_full, out_allocate_idx, out_empty} !== {1'b0, 4'd0, 1'b0})
      begin errors++; $display("FAIL full_drop: got full=%0d idx=%0d empty=%0d want 0 0 0", out_full, out_allocate_idx, out_empty); end
  endtask

  task automatic test_bypass();
    do_reset();
    alloc(5'd3, 1'b1, 32'h0);
    alloc(5'd3, 1'b1, 32'h4);
    in_ex_complete = 1; in_ex_complete_idx = 4'd0; in_ex_complete_value = 32'hA;
    tick(); idle();
    in_rs1 = 5'd3; in_rs2 = 5'd0;
    #1;
    checks++; if ({out_rs1_pending, out_rs1_bypass, out_rs1_bypass_value} !== {1'b1, 1'b0, 32'h0})
      begin errors++; $display("FAIL byp_pending: got p=%0d b=%0d v=%h want 1 0 0", out_rs1_pending, out_rs1_bypass, out_rs1_bypass_value); end
    in_ex_complete = 1; in_ex_complete_idx = 4'd1; in_ex_complete_value = 32'hB;
    tick();
    in_ex_complete = 0;
    #1;
    checks++; if ({out_rs1_pending, out_rs1_bypass, out_rs1_bypass_value} !== {1'b0, 1'b1, 32'hB})
      begin errors++; $display("FAIL byp_hit: got p=%0d b=%0d v=%h want 0 1 b", out_rs1_pending, out_rs1_bypass, out_rs1_bypass_value); end
    checks++; if ({out_rs2_pending, out_rs2_bypass, out_rs2_bypass_value} !== {1'b0, 1'b0, 32'h0})
      begin errors++; $display("FAIL byp_rs0: got p=%0d b=%0d v=%h want 0 0 0", out_rs2_pending, out_rs2_bypass, out_rs2_bypass_value); end
  endtask

  task automatic test_exception();
    do_reset();
    alloc(5'd1, 1'b1, 32'h100);
    alloc(5'd2, 1'b1, 32'h104);
    in_ex_complete = 1; in_ex_complete_idx = 4'd0; in_ex_exception_vector = 3'b010; in_ex_complete_value = 32'h7;
    in_mem_complete = 1; in_mem_complete_idx = 4'd1; in_mem_complete_value = 32'h8;
    tick(); idle();
    checks++; if ({out_exception, out_exception_vector, out_exception_PC, out_commit_valid, out_commit_write_enable} !== {1'b1, 3'd2, 32'h100, 1'b0, 1'b0})
      begin errors++; $display("FAIL exc_raise: got e=%0d vec=%0d pc=%h cv=%0d we=%0d want 1 2 100 0 0", out_exception, out_exception_vector, out_exception_PC, out_commit_valid, out_commit_write_enable); end
    alloc(5'd4, 1'b1, 32'h200);
    checks++; if ({out_exception, out_empty, out_allocate_idx, out_commit_valid} !== {1'b0, 1'b1, 4'd0, 1'b0})
      begin errors++; $display("FAIL exc_flush: got e=%0d empty=%0d idx=%0d cv=%0d want 0 1 0 0", out_exception, out_empty, out_allocate_idx, out_commit_valid); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    for (int i = 0; i < 5; i++) alloc(5'(10 + i), 1'b1, 32'(i * 4));
    in_ex_complete = 1; in_ex_complete_idx = 4'd4; in_ex_complete_value = 32'h1;
    in_mem_complete = 1; in_mem_complete_idx = 4'd4; in_mem_complete_value = 32'h2;
    tick(); idle();
    in_ex_complete = 1; in_ex_complete_idx = 4'd9; in_ex_complete_value = 32'hDEAD;
    tick(); idle();
    checks++; if ({out_allocate_idx, out_commit_valid, out_empty, out_full} !== {4'd5, 1'b0, 1'b0, 1'b0})
      begin errors++; $display("FAIL unalloc_cpl: got idx=%0d cv=%0d e=%0d f=%0d want 5 0 0 0", out_allocate_idx, out_commit_valid, out_empty, out_full); end
    in_ex_complete = 1; in_ex_complete_idx = 4'd3; in_ex_complete_value = 32'h103;
    in_mem_complete = 1; in_mem_complete_idx = 4'd2; in_mem_complete_value = 32'h102;
    tick();
    in_ex_complete_idx = 4'd1; in_ex_complete_value = 32'h101;
    in_mem_complete_idx = 4'd0; in_mem_complete_value = 32'h100;
    tick(); idle();
    for (int k = 0; k < 5; k++) begin
      logic [31:0] want;
      want = (k == 4) ? 32'h2 : 32'(32'h100 + k);
      checks++; if ({out_commit_valid, out_commit_rd, out_commit_value} !== {1'b1, 5'(10 + k), want})
        begin errors++; $display("FAIL dual_commit%0d: got v=%0d rd=%0d val=%h want 1 %0d %h", k, out_commit_valid, out_commit_rd, out_commit_value, 10 + k, want); end
      tick();
    end
    checks++; if (out_empty !== 1'b1) begin errors++; $display("FAIL dual_drain: got %0d want 1", out_empty); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < 5; i++) alloc(5'(i + 1), 1'b1, 32'(i));
    in_ex_complete = 1; in_ex_complete_idx = 4'd0; in_ex_complete_value = 32'h77;
    tick(); idle();
    in_rs1 = 5'd1;
    #1;
    checks++; if ({out_commit_valid, out_rs1_bypass} !== 2'b11) begin errors++; $display("FAIL pre_reset: got cv=%0d b=%0d want 1 1", out_commit_valid, out_rs1_bypass); end
    reset = 1;
    #1;
    checks++; if ({out_empty, out_full, out_allocate_idx, out_commit_valid, out_commit_value, out_exception, out_rs1_bypass, out_rs1_bypass_value, out_rs1_pending}
                  !== {1'b1, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0})
      begin errors++; $display("FAIL async_reset: got empty=%0d idx=%0d cv=%0d b=%0d p=%0d want 1 0 0 0 0", out_empty, out_allocate_idx, out_commit_valid, out_rs1_bypass, out_rs1_pending); end
    idle();
    tick();
    reset = 0;
    #1;
    checks++; if (out_allocate_idx !== 4'd0) begin errors++; $display("FAIL post_reset_idx: got %0d want 0", out_allocate_idx); end
    alloc(5'd8, 1'b1, 32'h0);
    checks++; if (out_allocate_idx !== 4'd1) begin errors++; $display("FAIL post_reset_alloc: got %0d want 1", out_allocate_idx); end
  endtask

  // Reference model: program-order queue of in-flight instructions.
  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [4:0]       rd;
    logic             we;
    logic [31:0]      pc;
    logic             cmp;
    logic [31:0]      val;
    logic [2:0]       exc;
  } ent_t;

  task automatic test_random();
    ent_t rob[$];
    int   m_tail = 0;
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int n;
      logic [4:0]  srcs [2];
      logic        eb [2];
      logic        ep [2];
      logic [31:0] ev [2];
      logic        e_cv, e_exc, e_we;
      logic [44:0] got_c, exp_c;
      logic [35:0] got_x, exp_x;
      logic [67:0] got_b, exp_b;
      n = rob.size();
      idle();
      in_allocate = ($urandom_range(0, 9) < 6);
      in_allocate_rd = 5'($urandom_range(0, 7));
      in_allocate_write_enable = 1'($urandom);
      in_allocate_PC = $urandom;
      in_ex_complete = 1'($urandom);
      in_ex_complete_idx = (n > 0 && $urandom_range(0, 3) != 0) ? rob[$urandom_range(0, n - 1)].idx : 4'($urandom);
      in_ex_complete_value = $urandom;
      in_ex_exception_vector = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      in_mem_complete = 1'($urandom);
      in_mem_complete_idx = (n > 0 && $urandom_range(0, 3) != 0) ? rob[$urandom_range(0, n - 1)].idx : 4'($urandom);
      in_mem_complete_value = $urandom;
      in_mem_exception_vector = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      in_rs1 = 5'($urandom_range(0, 7));
      in_rs2 = 5'($urandom_range(0, 7));
      #1;

      e_cv  = (n > 0) && rob[0].cmp && (rob[0].exc == 0);
      e_exc = (n > 0) && rob[0].cmp && (rob[0].exc != 0);
      e_we  = e_cv && rob[0].we && (rob[0].rd != 0);
      exp_c = {n == ENTRIES, n == 0, 4'(m_tail), e_cv, e_cv ? rob[0].rd : 5'd0, e_cv ? rob[0].val : 32'd0, e_we};
      exp_x = {e_exc, e_exc ? rob[0].exc : 3'd0, e_exc ? rob[0].pc : 32'd0};
      srcs[0] = in_rs1; srcs[1] = in_rs2;
      for (int s = 0; s < 2; s++) begin
        eb[s] = 0; ep[s] = 0; ev[s] = 0;
        if (srcs[s] != 0) begin
          for (int j = n - 1; j >= 0; j--) begin
            if (rob[j].we && rob[j].rd == srcs[s]) begin
              eb[s] = rob[j].cmp && (rob[j].exc == 0);
              ep[s] = !rob[j].cmp;
              ev[s] = eb[s] ? rob[j].val : 32'd0;
              break;
            end
          end
        end
      end
      exp_b = {eb[0], ep[0], ev[0], eb[1], ep[1], ev[1]};
      got_c = {out_full, out_empty, out_allocate_idx, out_commit_valid, out_commit_rd, out_commit_value, out_commit_write_enable};
      got_x = {out_exception, out_exception_vector, out_exception_PC};
      got_b = {out_rs1_bypass, out_rs1_pending, out_rs1_bypass_value, out_rs2_bypass, out_rs2_pending, out_rs2_bypass_value};
      checks++; if (got_c !== exp_c) begin errors++; $display("FAIL rnd_commit cyc %0d: got %h want %h", cyc, got_c, exp_c); end
      checks++; if (got_x !== exp_x) begin errors++; $display("FAIL rnd_exc cyc %0d: got %h want %h", cyc, got_x, exp_x); end
      checks++; if (got_b !== exp_b) begin errors++; $display("FAIL rnd_bypass cyc %0d: got %h want %h", cyc, got_b, exp_b); end

      tick();

      if (e_exc) begin
        rob.delete();
        m_tail = 0;
      end else begin
        for (int j = 0; j < n; j++) begin
          ent_t e;
          e = rob[j];
          if (in_ex_complete && e.idx == in_ex_complete_idx) begin
            e.cmp = 1; e.val = in_ex_complete_value; e.exc = in_ex_exception_vector;
          end
          if (in_mem_complete && e.idx == in_mem_complete_idx) begin
            e.cmp = 1; e.val = in_mem_complete_value; e.exc = in_mem_exception_vector;
          end
          rob[j] = e;
        end
        if (e_cv) void'(rob.pop_front());
        if (in_allocate && n < ENTRIES) begin
          ent_t e;
          e.idx = 4'(m_tail); e.rd = in_allocate_rd; e.we = in_allocate_write_enable;
          e.pc = in_allocate_PC; e.cmp = 0; e.val = 0; e.exc = 0;
          rob.push_back(e);
          m_tail = (m_tail + 1) % ENTRIES;
        end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    test_reset();
    test_inorder_commit();
    test_full();
    test_bypass();
    test_exception();
    test_same_cycle();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Sixteen-entry in-order reorder buffer: the receiving end of the completion interface driven by the execute and memory stages. Decode allocates entries in program order. Execute and memory write back results and exception vectors by entry index. The buffer retires one entry per cycle to the register file. It also answers rs1/rs2 bypass queries for execute and raises precise exceptions at commit.

## Interface
- ENTRIES, 16: entry count, power of two.
- IDX_W, 4: log2(ENTRIES).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_allocate  in  1  decode requests a new entry.
- in_allocate_rd  in  5  destination register.
- in_allocate_write_enable  in  1  instruction writes rd.
- in_allocate_PC  in  32  instruction PC.
- out_allocate_idx  out  IDX_W  index granted (current tail).
- out_full / out_empty  out  1  count==ENTRIES / count==0.
- in_ex_complete, in_ex_complete_idx[IDX_W], in_ex_complete_value[32], in_ex_exception_vector[3]  in  execute completion port.
- in_mem_complete, in_mem_complete_idx[IDX_W], in_mem_complete_value[32], in_mem_exception_vector[3]  in  memory-stage completion port.
- in_rs1, in_rs2  in  5  source registers queried by execute.
- out_rs1_bypass, out_rs2_bypass  out  1  forwarded value valid.
- out_rs1_bypass_value, out_rs2_bypass_value  out  32  forwarded value.
- out_rs1_pending, out_rs2_pending  out  1  youngest producer is not yet complete; the hazard unit stalls.
- out_commit_valid  out  1  head retires this cycle.
- out_commit_rd  out  5; out_commit_value  out  32; out_commit_write_enable  out  1  register file write.
- out_exception  out  1  head retires with a nonzero exception vector.
- out_exception_vector  out  3; out_exception_PC  out  32.

## Operation
- State:
  - per entry: valid, complete, rd, write_enable, PC, value, exception_vector;
  - head, tail (IDX_W, wrap modulo ENTRIES);
  - count (IDX_W+1).
- Allocate:
  - Accepted when in_allocate && !out_full && !out_exception.
  - The entry at tail gets valid=1, complete=0, exception_vector=0 and the supplied fields; tail+1.
  - A rejected request changes nothing.
- Complete:
  - Port fires when asserted and the target entry is valid.
  - Firing sets complete=1 and stores the value and exception vector.
  - A port targeting an invalid entry is ignored.
  - Both ports on the same idx in the same cycle: the mem port wins.
- Commit:
  - Head valid && complete && exception_vector==0 → out_commit_valid=1.
  - out_commit_write_enable = entry write_enable && rd!=0.
  - On the clock edge: clear valid, head+1.
- Exception:
  - Head valid && complete && exception_vector!=0 → out_exception=1 with the vector and PC.
  - out_commit_valid=0; no register write.
  - On the edge: flush all entries, head=tail=count=0. Completions and allocations in that cycle are discarded.
- count:
  - +1 on an accepted allocate, −1 on a commit; both in one cycle → unchanged.
  - Exception forces count to 0.
- Bypass per source:
  - Search for the youngest valid entry (nearest tail) with write_enable && rd==rs && rs!=0.
  - Match found and complete with exception 0 → bypass=1, value driven.
  - Match found but incomplete → pending=1, bypass=0.
  - No match, or rs==0 → both 0 and value 0.

## Timing
- All outputs are combinational from registered state only. No combinational path runs from complete ports to commit or bypass outputs.
- Allocation at edge N: the entry is visible to bypass and commit from cycle N+1.
- Completion at edge N: earliest commit, and earliest bypass, is cycle N+1.
- Full with commit in the same cycle: allocation is still refused, because full uses registered count.
- Reset values:
  - out_empty=1, out_allocate_idx=0.
  - All other outputs 0.
  - Reset mid-operation drops all in-flight entries asynchronously.

## Test plan
- Allocate rd=5, 6, 7 (idx 0, 1, 2); complete idx 1 value 0x22 then idx 0 value 0x11 → commits rd5=0x11 then rd6=0x22 in consecutive cycles; idx 2 is held.
- Allocate 16 entries → out_full=1; a 17th allocate is ignored and tail stays 0; commit one → full drops the following cycle.
- Two entries writing rd=3, the older complete with 0xA and the younger incomplete; query rs1=3 → pending=1, bypass=0. Complete the younger with 0xB → bypass=1, value 0xB. Query rs2=0 → no bypass.
- Complete idx 0 with exception 3'b010 at PC 0x100, idx 1 complete → out_exception=1 for one cycle, vector 2, PC 0x100, no commit; next cycle out_empty=1, tail=0.
- Same-cycle ex/mem completion of idx 4 (0x1 vs 0x2) → committed value 0x2. Completion to an unallocated idx → no effect.
- Assert reset with 5 entries in flight → out_empty=1 and all outputs 0 immediately; after deassert, the first allocate gets idx 0.
